// File: rtl/sync_fifo.sv
// Single-clock FIFO, any integer depth, registered-read or first-word-fall-through output.
// Latency: write visible to flags at the accepting edge; FWFT=0 read data one edge after accept, FWFT=1 data follows head.
// Backpressure: writes while full are dropped (overflow), reads while empty are ignored (underflow); both sticky.
module sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       flush,
    input  logic                       clr_err,
    input  logic                       w_enable,
    input  logic [WIDTH-1:0]           w_data,
    input  logic                       r_enable,
    output logic [WIDTH-1:0]           r_data,
    output logic                       r_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_LVL   = LW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;

    logic wr_acc;
    logic rd_acc;
    logic ovf_set;
    logic unf_set;

    // Flags are pure decodes of the registered occupancy, so they never glitch.
    assign full         = (level == LVL_FULL);
    assign empty        = (level == '0);
    assign almost_full  = (level >= AF_LVL);
    assign almost_empty = (level <= AE_LVL);

    // Flush swallows the cycle's requests entirely, including their error side effects.
    assign wr_acc  = w_enable && !full  && !flush;
    assign rd_acc  = r_enable && !empty && !flush;
    assign ovf_set = w_enable &&  full  && !flush;
    assign unf_set = r_enable &&  empty && !flush;

    // Storage array is deliberately left unreset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr] <= w_data;
        end
    end

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
            end
        end
    end

    // Occupancy moves only when exactly one side is accepted.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            level <= '0;
        end else if (flush) begin
            level <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky error flags: a new event beats a same-cycle clear; flush leaves them alone.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!flush) begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is presented directly; zeroed when nothing is stored.
            assign r_data  = empty ? '0 : mem[rptr];
            assign r_valid = !empty;
        end else begin : g_reg
            // Registered read: data captured on accept, valid pulses for one cycle.
            always_ff @(posedge clk or negedge aresetn) begin
                if (!aresetn) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else if (flush) begin
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= rd_acc;
                    if (rd_acc) begin
                        r_data <= mem[rptr];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a DEPTH=5 registered-read instance and a DEPTH=8 FWFT instance share stimulus.
// Queue scoreboards track expected contents; a vector table and short sequences add hand-written expectations.
// Inputs are driven after the falling edge and outputs sampled 1 time unit after the rising edge.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       aresetn;
    logic       flush;
    logic       clr_err;
    logic       w_enable;
    logic [7:0] w_data;
    logic       r_enable;

    logic [7:0] rd5;
    logic       rv5, full5, empty5, af5, ae5, ovf5, unf5;
    logic [2:0] lvl5;
    logic [7:0] rd8;
    logic       rv8, full8, empty8, af8, ae8, ovf8, unf8;
    logic [3:0] lvl8;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q5[$];
    logic [7:0] q8[$];
    bit         m_ovf5, m_unf5, m_ovf8, m_unf8, m_rv5;
    logic [7:0] m_rd5;

    typedef struct {
        bit         fl;
        bit         ce;
        bit         we;
        logic [7:0] wd;
        bit         re;
        int         lvl;
        bit         ovf;
        bit         unf;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_d5 (
        .clk(clk), .aresetn(aresetn), .flush(flush), .clr_err(clr_err),
        .w_enable(w_enable), .w_data(w_data), .r_enable(r_enable),
        .r_data(rd5), .r_valid(rv5), .full(full5), .empty(empty5),
        .almost_full(af5), .almost_empty(ae5), .level(lvl5),
        .overflow(ovf5), .underflow(unf5)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)) u_d8 (
        .clk(clk), .aresetn(aresetn), .flush(flush), .clr_err(clr_err),
        .w_enable(w_enable), .w_data(w_data), .r_enable(r_enable),
        .r_data(rd8), .r_valid(rv8), .full(full8), .empty(empty8),
        .almost_full(af8), .almost_empty(ae8), .level(lvl8),
        .overflow(ovf8), .underflow(unf8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q5.delete();
        q8.delete();
        m_ovf5 = 0; m_unf5 = 0; m_ovf8 = 0; m_unf8 = 0;
        m_rv5  = 0; m_rd5  = 8'h00;
    endtask

    // Advance both queue models by one rising edge using the current inputs.
    task automatic model_edge();
        bit f5, e5, f8, e8;
        f5 = (q5.size() == 5); e5 = (q5.size() == 0);
        f8 = (q8.size() == 8); e8 = (q8.size() == 0);
        if (flush) begin
            q5.delete();
            q8.delete();
            m_rv5 = 0;
        end else begin
            if (w_enable && f5) m_ovf5 = 1; else if (clr_err) m_ovf5 = 0;
            if (r_enable && e5) m_unf5 = 1; else if (clr_err) m_unf5 = 0;
            if (w_enable && f8) m_ovf8 = 1; else if (clr_err) m_ovf8 = 0;
            if (r_enable && e8) m_unf8 = 1; else if (clr_err) m_unf8 = 0;
            m_rv5 = 0;
            if (r_enable && !e5) begin
                m_rd5 = q5.pop_front();
                m_rv5 = 1;
            end
            if (w_enable && !f5) q5.push_back(w_data);
            if (r_enable && !e8) void'(q8.pop_front());
            if (w_enable && !f8) q8.push_back(w_data);
        end
    endtask

    task automatic check_all();
        int n5, n8;
        n5 = q5.size();
        n8 = q8.size();
        chk("d5_level", 32'(lvl5), n5);
        chk("d5_full", 32'(full5), 32'(n5 == 5));
        chk("d5_empty", 32'(empty5), 32'(n5 == 0));
        chk("d5_afull", 32'(af5), 32'(n5 >= 3));
        chk("d5_aempty", 32'(ae5), 32'(n5 <= 2));
        chk("d5_rvalid", 32'(rv5), 32'(m_rv5));
        chk("d5_rdata", 32'(rd5), 32'(m_rd5));
        chk("d5_ovf", 32'(ovf5), 32'(m_ovf5));
        chk("d5_unf", 32'(unf5), 32'(m_unf5));
        chk("d8_level", 32'(lvl8), n8);
        chk("d8_full", 32'(full8), 32'(n8 == 8));
        chk("d8_empty", 32'(empty8), 32'(n8 == 0));
        chk("d8_afull", 32'(af8), 32'(n8 >= 6));
        chk("d8_aempty", 32'(ae8), 32'(n8 <= 2));
        chk("d8_rvalid", 32'(rv8), 32'(n8 != 0));
        chk("d8_rdata", 32'(rd8), (n8 != 0) ? 32'(q8[0]) : 32'h0);
        chk("d8_ovf", 32'(ovf8), 32'(m_ovf8));
        chk("d8_unf", 32'(unf8), 32'(m_unf8));
    endtask

    task automatic step(input bit fl, input bit ce, input bit we, input logic [7:0] wd, input bit re);
        @(negedge clk);
        flush = fl; clr_err = ce; w_enable = we; w_data = wd; r_enable = re;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    function automatic void add(input bit fl, input bit ce, input bit we, input logic [7:0] wd,
                                input bit re, input int lvl, input bit ovf, input bit unf);
        vec_t v;
        v.fl = fl; v.ce = ce; v.we = we; v.wd = wd; v.re = re;
        v.lvl = lvl; v.ovf = ovf; v.unf = unf;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [8:0] ae_exp;
        logic [8:0] af_exp;
        ae_exp = 9'b0_0000_0111;
        af_exp = 9'b1_1100_0000;

        // Expected state of the DEPTH=5 instance after each vector.
        for (int i = 1; i <= 5; i++) add(0, 0, 1, 8'(i), 0, i, 0, 0);
        add(0, 0, 1, 8'h06, 0, 5, 1, 0);
        for (int i = 4; i >= 0; i--) add(0, 0, 0, 8'h00, 1, i, 1, 0);
        add(0, 0, 0, 8'h00, 1, 0, 1, 1);
        add(0, 1, 0, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 1, 8'(8'h10 + i), 0, i + 1, 0, 0);
        add(0, 0, 1, 8'h15, 1, 4, 1, 0);
        add(0, 0, 0, 8'h00, 1, 3, 1, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 1, 8'(8'h20 + i), 1, 3, 1, 0);
        add(0, 1, 0, 8'h00, 0, 3, 0, 0);
        for (int i = 2; i >= 0; i--) add(0, 0, 0, 8'h00, 1, i, 0, 0);
        add(0, 0, 1, 8'h30, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 8'(8'h31 + i), 0, i + 2, 0, 1);
        add(1, 0, 1, 8'h40, 1, 0, 0, 1);
        add(0, 1, 0, 8'h00, 1, 0, 0, 1);
        add(0, 1, 0, 8'h00, 0, 0, 0, 0);

        aresetn = 1'b0; flush = 0; clr_err = 0; w_enable = 0; w_data = 0; r_enable = 0;
        model_reset();
        #12;
        check_all();
        chk("rst_d5_aempty", 32'(ae5), 32'd1);
        chk("rst_d5_rdata", 32'(rd5), 32'd0);
        @(negedge clk);
        aresetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].fl, tbl[i].ce, tbl[i].we, tbl[i].wd, tbl[i].re);
            chk($sformatf("vec%0d_level", i), 32'(lvl5), tbl[i].lvl);
            chk($sformatf("vec%0d_ovf", i), 32'(ovf5), 32'(tbl[i].ovf));
            chk($sformatf("vec%0d_unf", i), 32'(unf5), 32'(tbl[i].unf));
        end

        // Threshold sweep on the DEPTH=8 instance, up and back down.
        step(1, 0, 0, 8'h00, 0);
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 1, 8'(8'h50 + k), 0);
            chk($sformatf("thr_up%0d_ae", k), 32'(ae8), 32'(ae_exp[k]));
            chk($sformatf("thr_up%0d_af", k), 32'(af8), 32'(af_exp[k]));
        end
        step(0, 0, 1, 8'h5F, 0);
        chk("d8_full_drop_ovf", 32'(ovf8), 32'd1);
        for (int k = 7; k >= 0; k--) begin
            step(0, 0, 0, 8'h00, 1);
            chk($sformatf("thr_dn%0d_ae", k), 32'(ae8), 32'(ae_exp[k]));
            chk($sformatf("thr_dn%0d_af", k), 32'(af8), 32'(af_exp[k]));
        end
        step(0, 1, 0, 8'h00, 0);

        // First-word fall-through: word appears with no read request, pop empties it.
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 1, 8'hA5, 0);
        chk("fwft_rvalid", 32'(rv8), 32'd1);
        chk("fwft_rdata", 32'(rd8), 32'hA5);
        step(0, 0, 0, 8'h00, 1);
        chk("fwft_pop_rvalid", 32'(rv8), 32'd0);
        chk("fwft_pop_rdata", 32'(rd8), 32'h00);

        // Asynchronous reset in the middle of traffic.
        step(0, 0, 1, 8'h11, 0);
        step(0, 0, 1, 8'h22, 1);
        step(0, 0, 1, 8'h33, 1);
        @(negedge clk);
        w_enable = 1; w_data = 8'h44; r_enable = 1; clr_err = 0; flush = 0;
        #2;
        aresetn = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        w_enable = 0; r_enable = 0;
        aresetn = 1'b1;
        step(0, 0, 0, 8'h00, 0);
        chk("post_rst_rvalid", 32'(rv5), 32'd0);
        step(0, 0, 0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO for buffering data within one clock domain, e.g. on either side of a clock-domain crossing. Generalises the team's FIFO pointer scheme to any integer depth (not only powers of two) and adds a selectable first-word-fall-through read mode. It also provides an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.

## Interface
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 16, number of entries (any integer >=2)
- FWFT, 0, read mode: 0 = registered read, 1 = first-word fall-through
- AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH (0..DEPTH-1)
- clk  in  1  clock, all logic on rising edge
- aresetn  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of contents
- clr_err  in  1  clears overflow/underflow
- w_enable  in  1  write request
- w_data  in  WIDTH  write data
- r_enable  in  1  read request
- r_data  out  WIDTH  read data
- r_valid  out  1  r_data holds a valid word (see Operation)
- full / empty  out  1  level==DEPTH / level==0
- almost_full / almost_empty  out  1  threshold flags
- level  out  $clog2(DEPTH+1)  current occupancy 0..DEPTH
- overflow / underflow  out  1  sticky error flags

## Operation
- Storage: DEPTH x WIDTH array, not reset. wptr/rptr range 0..DEPTH-1; increment wraps DEPTH-1 -> 0 by explicit compare (no power-of-two masking).
- Write accepted iff w_enable && !full: mem[wptr] <= w_data, wptr advances.
- Read accepted iff r_enable && !empty: rptr advances.
- Write while full is dropped, even with a simultaneous accepted read. Sets overflow.
- Read while empty is ignored. Sets underflow. An accepted write in the same cycle still happens.
- level: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Flags are decoded from the registered level:
  - full = (level==DEPTH), empty = (level==0)
  - almost_full = (level>=AF_THRESH), almost_empty = (level<=AE_THRESH)
- FWFT=0:
  - r_data is a register, loaded with mem[rptr] on an accepted read.
  - r_valid pulses 1 for the single cycle after the accept.
  - r_data holds its value otherwise.
- FWFT=1:
  - r_data = mem[rptr] whenever !empty, forced to 0 when empty.
  - r_valid = !empty.
  - An accepted read pops the presented word.
- overflow/underflow are sticky until clr_err. If a new set and clr_err occur in the same cycle, set wins.
- flush (highest priority, not an error):
  - next edge: wptr = rptr = level = 0.
  - That cycle's write/read are discarded; no error flags set.
  - overflow/underflow are not changed.
  - FWFT=0: r_valid <= 0, r_data holds.
- Reset (async assert, synchronous-safe release), output values:
  - level=0, empty=1, almost_empty=1, full=0
  - almost_full=0, since AF_THRESH>=1
  - r_data=0, r_valid=0, overflow=0, underflow=0
- Reset mid-operation discards all contents.

## Timing
- All outputs change only on rising clk, except asynchronously on reset. FWFT=1 r_data/r_valid follow rptr, level and memory, which are all registered.
- Write accepted at edge N: level/empty/flags update at N, so the word is readable from cycle N+1.
- FWFT=0 read accepted at edge M: r_data/r_valid valid after M, for one cycle (r_valid). Write-to-data latency 2 edges.
- FWFT=1: write at edge N, r_data valid after N (1 edge latency).
- Back-to-back writes and reads sustain 1 word/cycle. Full throughput with simultaneous read+write at 0<level<DEPTH.
- Full -> not-full: read at edge M clears full after M; a write at edge M is still dropped.

## Test plan
- Reset:
  - Stimulus: assert aresetn=0 mid-traffic.
  - Response: all outputs at reset values immediately (empty=1, level=0, r_data=0, r_valid=0, flags 0); no pop after release.
- Fill/drain with wrap (DEPTH=5, FWFT=0):
  - Stimulus: write 0x01..0x05, then write 0x06; read 5 times.
  - Response:
    - full=1 at level 5; 0x06 dropped, overflow=1.
    - Reads return 0x01..0x05 each one cycle after accept, with r_valid pulses.
    - Then empty=1; pointers wrap cleanly on a second pass of 0x10..0x14.
- Simultaneous read+write:
  - Stimulus: at level 3, read+write for 10 cycles.
  - Response: level stays 3, data order preserved.
  - Corner cases:
    - At level 0: read rejected, underflow=1, level -> 1.
    - At level DEPTH: write dropped, level -> DEPTH-1.
- Thresholds (DEPTH=8, AF=6, AE=2):
  - almost_empty=1 for level 0..2, 0 at 3.
  - almost_full=0 at 5, 1 at 6..8.
- FWFT=1:
  - Stimulus: write 0xA5 into empty.
  - Response:
    - After that edge, r_valid=1 and r_data=0xA5 without r_enable.
    - Pop: r_valid=0, r_data=0.
- Flush/clr_err:
  - At level 4, flush with w_enable=1 and r_enable=1 -> level=0, empty=1, no error flags set.
  - clr_err clears sticky flags.
  - clr_err coincident with underflow -> underflow stays 1.
